// File: rtl/fpu_pkg.sv
// Shared FPU types: rounding modes, exception flags and
// encodings for the special results of a float format.
package fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } roundmode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Encodings are returned right-aligned; callers truncate to their width.
    function automatic logic [63:0] fp_inf(
        input int   ew,
        input int   mw,
        input logic sign
    );
        logic [63:0] r;
        r = ((64'd1 << ew) - 64'd1) << mw;
        r = r | ({63'd0, sign} << (ew + mw));
        return r;
    endfunction

    function automatic logic [63:0] fp_max_finite(
        input int   ew,
        input int   mw,
        input logic sign
    );
        logic [63:0] r;
        r = ((64'd1 << ew) - 64'd2) << mw;
        r = r | ((64'd1 << mw) - 64'd1);
        r = r | ({63'd0, sign} << (ew + mw));
        return r;
    endfunction

endpackage

// File: rtl/fpu_int2fp_pipe_if.sv
// Operand/result handshake bundle of the int-to-float converter.
// master drives operands and out_ready_i; slave is the converter.
interface fpu_int2fp_pipe_if #(
    parameter int INT_W = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [INT_W-1:0]       int_i;
    logic                   unsigned_i;
    logic [2:0]             rm_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [EXP_W+MAN_W:0]   fp_o;
    logic [4:0]             status_o;

    modport master (
        output in_valid_i,
        output int_i,
        output unsigned_i,
        output rm_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  fp_o,
        input  status_o
    );

    modport slave (
        input  in_valid_i,
        input  int_i,
        input  unsigned_i,
        input  rm_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output fp_o,
        output status_o
    );
endinterface

// File: rtl/fpu_lzc.sv
// Leading-zero counter with all-zero flag; count is 0 for zero input.
module fpu_lzc #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);
    // Highest set bit wins because it is visited last.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) cnt = CNT_W'(WIDTH - 1 - i);
        end
    end

    assign zero = ~|data;
endmodule

// File: rtl/fpu_int2fp_pipe.sv
// Three-stage integer to float converter: capture, normalise,
// round/pack, with a collapsing valid/ready pipeline.
module fpu_int2fp_pipe
    import fpu_pkg::*;
#(
    parameter int INT_W = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input logic             clk_i,
    input logic             rst_ni,
    fpu_int2fp_pipe_if.slave io
);
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int FP_W = 1 + EXP_W + MAN_W;
    localparam int LZ_W = $clog2(INT_W);
    localparam int CW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
    localparam int FW   = INT_W + MAN_W + 1;
    localparam logic [CW-1:0] EMAX = CW'((2 ** EXP_W) - 1);

    if (INT_W < 2 || EXP_W < 2 || MAN_W < 1 || EXP_W + MAN_W > 62)
    begin : g_bad_fmt
        $error("fpu_int2fp_pipe: unsupported format");
    end

    logic              s1_valid, s2_valid, s3_valid;
    logic              ld1, ld2, ld3;

    assign ld3 = !s3_valid || io.out_ready_i;
    assign ld2 = !s2_valid || ld3;
    assign ld1 = !s1_valid || ld2;
    assign io.in_ready_o = ld1;

    // S1: capture sign and magnitude
    logic              in_sign;
    logic              s1_sign;
    logic [INT_W-1:0]  s1_mag;
    logic [2:0]        s1_rm;

    assign in_sign = !io.unsigned_i && io.int_i[INT_W-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_rm    <= '0;
        end else if (ld1) begin
            s1_valid <= io.in_valid_i;
            if (io.in_valid_i) begin
                s1_sign <= in_sign;
                s1_mag  <= in_sign ? -io.int_i : io.int_i;
                s1_rm   <= io.rm_i;
            end
        end
    end

    // S2: normalise; the hidden bit is implied by !zero
    logic [LZ_W-1:0]   lz;
    logic              mag_zero;
    logic              s2_sign, s2_zero;
    logic [INT_W-2:0]  s2_frac;
    logic [CW-1:0]     s2_exp;
    logic [2:0]        s2_rm;

    fpu_lzc #(.WIDTH(INT_W)) u_lzc (
        .data (s1_mag),
        .cnt  (lz),
        .zero (mag_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_frac  <= '0;
            s2_exp   <= '0;
            s2_rm    <= '0;
        end else if (ld2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_zero <= mag_zero;
                s2_frac <= (INT_W-1)'(s1_mag << lz);
                s2_exp  <= CW'(INT_W - 1) - CW'(lz);
                s2_rm   <= s1_rm;
            end
        end
    end

    // S3: round and pack
    logic [FW-1:0]     ext;
    logic [MAN_W-1:0]  kept;
    logic              guard, sticky;
    logic              m_rtz, m_rdn, m_rup, m_rmm;
    logic              rnd_inc, to_inf;
    logic [MAN_W:0]    man_sum;
    logic [CW-1:0]     bexp;
    logic              ovf;
    logic [FP_W-1:0]   fp_nxt;
    fflags_t           st_nxt;

    // Zero padding makes narrow integers exact without a special case.
    assign ext    = {s2_frac, {(MAN_W + 2){1'b0}}};
    assign kept   = ext[FW-1 -: MAN_W];
    assign guard  = ext[FW-1-MAN_W];
    assign sticky = |ext[FW-2-MAN_W:0];

    assign m_rtz = (s2_rm == RTZ);
    assign m_rdn = (s2_rm == RDN);
    assign m_rup = (s2_rm == RUP);
    assign m_rmm = (s2_rm == RMM);

    always_comb begin
        rnd_inc = guard & (sticky | kept[0]);
        to_inf  = 1'b1;
        unique case (1'b1)
            m_rtz: begin
                rnd_inc = 1'b0;
                to_inf  = 1'b0;
            end
            m_rdn: begin
                rnd_inc = s2_sign & (guard | sticky);
                to_inf  = s2_sign;
            end
            m_rup: begin
                rnd_inc = !s2_sign & (guard | sticky);
                to_inf  = !s2_sign;
            end
            m_rmm: rnd_inc = guard;
            default: ;
        endcase
    end

    assign man_sum = {1'b0, kept} + {{MAN_W{1'b0}}, rnd_inc};
    assign bexp    = s2_exp + CW'(BIAS)
                   + {{(CW-1){1'b0}}, man_sum[MAN_W]};
    assign ovf     = (bexp >= EMAX);

    always_comb begin
        fp_nxt = '0;
        st_nxt = '0;
        if (!s2_zero) begin
            st_nxt.nx = guard | sticky;
            if (ovf) begin
                st_nxt.of = 1'b1;
                st_nxt.nx = 1'b1;
                fp_nxt = to_inf
                    ? FP_W'(fp_inf(EXP_W, MAN_W, s2_sign))
                    : FP_W'(fp_max_finite(EXP_W, MAN_W, s2_sign));
            end else begin
                fp_nxt = {s2_sign, bexp[EXP_W-1:0],
                          man_sum[MAN_W-1:0]};
            end
        end
    end

    logic [FP_W-1:0]   s3_fp;
    fflags_t           s3_st;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s3_valid <= 1'b0;
            s3_fp    <= '0;
            s3_st    <= '0;
        end else if (ld3) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_fp <= fp_nxt;
                s3_st <= st_nxt;
            end
        end
    end

    assign io.out_valid_o = s3_valid;
    assign io.fp_o        = s3_fp;
    assign io.status_o    = s3_st;
endmodule

// File: doc/fpu_int2fp_pipe.md
Name: fpu_int2fp_pipe

Overview:
- Pipelined integer-to-floating-point converter for the FPU datapath.
- Generalises the combinational int-to-bfloat16 converter in four ways:
  - parametrised integer and float formats;
  - all five RISC-V rounding modes;
  - RISC-V exception flags;
  - valid/ready handshake with backpressure through a 3-stage pipeline.
- Sits between the FPU operand mux and the FPU result writeback arbiter.

Parameters:
- INT_W, 32: integer operand width, >= 2.
- EXP_W, 8: float exponent width. 8 with MAN_W=7 is bfloat16; 5 with MAN_W=10 is fp16.
- MAN_W, 7: stored mantissa width, excluding the hidden bit.
- BIAS, 2**(EXP_W-1)-1: exponent bias; derived, do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  stage 1 can accept
- int_i  in  INT_W  integer operand
- unsigned_i  in  1  1: int_i is unsigned; 0: two's complement
- rm_i  in  3  rounding mode (fpu_pkg::roundmode_e)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts
- fp_o  out  1+EXP_W+MAN_W  packed result {sign, exp, man}
- status_o  out  5  fflags {NV,DZ,OF,UF,NX}; NV, DZ, UF are always 0

Behaviour:
- Reset (async, rst_ni=0): all stage valid bits clear.
  - out_valid_o=0, fp_o=0, status_o=0.
  - in_ready_o=1 after reset release.
  - Any in-flight operations are discarded.
- Handshake:
  - Transfer on in_valid_i&in_ready_o, and on out_valid_o&out_ready_i.
  - Stage k loads when stage k is empty or stage k+1 loads. Stage 3's downstream is out_ready_i.
  - Bubbles collapse.
  - in_ready_o = !s1_valid | s1_advances. It is combinational from out_ready_i through the pipe.
  - Once asserted, out_valid_o and fp_o/status_o stay stable until accepted.
- Latency: accept at edge N gives out_valid_o=1 in the cycle after edge N+2 (3 cycles) when not stalled. Throughput is 1 per cycle.
- Order is preserved; no drops, no duplicates.
- S1 (capture):
  - sign = !unsigned_i & int_i[INT_W-1].
  - mag = sign ? -int_i : int_i, in INT_W bits unsigned. INT_MIN gives 2**(INT_W-1), correctly.
  - Latch rm_i per operation; a later rm_i change never affects in-flight ops.
- S2 (normalise):
  - lz = leading-zero count of mag (fpu_lzc).
  - norm = mag << lz, so the MSB is the hidden bit.
  - unbiased exponent e = INT_W-1-lz.
  - zero flag when mag==0.
- S3 (round/pack):
  - kept = norm[INT_W-2 -: MAN_W].
  - guard = next bit; sticky = OR of the remaining bits. If INT_W-1 <= MAN_W, pad with zeros: exact, guard=sticky=0.
  - Round increment:
    - RNE: guard&(sticky|lsb)
    - RTZ: 0
    - RDN: sign&(guard|sticky)
    - RUP: !sign&(guard|sticky)
    - RMM: guard
  - Mantissa carry-out: man=0 and e+1.
  - NX = guard|sticky.
  - Reserved rm (101–111) is treated as RNE.
- Zero: mag==0 gives fp_o=0 (positive zero, even for RDN) and status_o=0.
- Overflow, when e+BIAS >= 2**EXP_W-1 after rounding: set OF=1 and NX=1. Result by mode:
  - RNE/RMM: ±inf.
  - RTZ: ±max-finite.
  - RDN: +max-finite or -inf.
  - RUP: +inf or -max-finite.
- Elaboration assertion: EXP_W>=2, MAN_W>=1. Underflow is impossible for integer inputs.

Decomposition:
- fpu_pkg holds:
  - roundmode_e: RNE=3'b000, RTZ=001, RDN=010, RUP=011, RMM=100.
  - fflags_t packed struct {nv,dz,of,uf,nx}.
  - Helper functions for max-finite and inf encodings given EXP_W/MAN_W.
- One sub-module: fpu_lzc (parametrised WIDTH, combinational leading-zero count plus all-zero flag), instantiated in S2.

Test Plan:
- bf16, signed: int 1 → 0x3F80; int 0xFFFFFFFF → 0xBF80; int 0x80000000 → 0xCF00. All flags 0.
- bf16, unsigned, RNE: 0xFFFFFFFF → 0x4F80, NX=1. The carry-out increments the exponent to 0x9F.
- bf16 ties, unsigned, int 387 (0x183):
  - RNE → 0x43C2, NX=1.
  - RTZ → 0x43C1.
  - int 385, RNE → 0x43C0 (tie to even, rounds down).
  - int 384 → 0x43C0, NX=0.
- fp16 (EXP_W=5, MAN_W=10), int 65536, OF=1/NX=1 in every case:
  - RNE → 0x7C00.
  - RTZ → 0x7BFF.
  - Signed −65536, RUP → 0xFBFF.
- Zero and backpressure:
  - int 0 with RDN → 0x0000, flags 0.
  - Stream 6 back-to-back operands with out_ready_i=0 for 5 cycles: in_ready_o drops after 3 are accepted, then all 6 results emerge in order with no loss.
- Reset mid-flight: assert rst_ni=0 with 2 ops in the pipe. out_valid_o=0 immediately; after release, the next op produces exactly one result with 3-cycle latency.
